// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC, single-outstanding imem handshake and instruction holding register.
// Define FETCH_HALT_EN to enable HLT detection and the HALTED state.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OP   = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_plus1,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic        halt
);
`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;
`else
    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
`endif
    state_t state, state_d;
    logic [15:0] pc;
    logic consume, is_hlt;
    assign consume = (state == HOLD) && !stall;
`ifdef FETCH_HALT_EN
    assign is_hlt = instr[15:12] == HLT_OP;
`else
    logic unused_hlt_op;
    assign unused_hlt_op = ^HLT_OP;
    assign is_hlt = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_d;
    end
    always_comb begin
        state_d = (state == FETCH && imem_gnt)    ? WAIT :
                  (state == WAIT  && imem_rvalid) ? HOLD :
`ifdef FETCH_HALT_EN
                  consume                         ? (is_hlt ? HALTED : FETCH) :
`else
                  consume                         ? FETCH :
`endif
                  state;
    end
    always_comb begin
        imem_req    = (state == FETCH) && !rst;
        imem_addr   = pc;
        instr_valid = state == HOLD;
        pc_plus1    = instr_pc + 16'd1;
`ifdef FETCH_HALT_EN
        halt        = state == HALTED;
`else
        halt        = 1'b0;
`endif
    end
    // rvalid is only meaningful while a request is outstanding; elsewhere it is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            instr    <= 16'h0000;
            instr_pc <= 16'h0000;
        end else begin
            if (state == WAIT && imem_rvalid) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (consume && !is_hlt) pc <= br_taken ? br_target : pc + 16'd1;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: per-cycle vector table for pc_fetch_unit plus a halt-hold sequence.
module tb_pc_fetch_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic imem_req, imem_gnt, imem_rvalid, instr_valid, stall, br_taken, halt;
    logic [15:0] imem_addr, imem_rdata, instr, instr_pc, pc_plus1, br_target;
    int checks = 0, fails = 0;
    typedef struct {
        logic [2:0]  ctl;
        logic [15:0] rdata;
        logic [1:0]  sb;
        logic [15:0] target;
        logic [2:0]  ex;
        logic [15:0] addr, instr, ipc, p1;
    } vec_t;
    vec_t va[$], vb[$];
    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc), .pc_plus1(pc_plus1),
        .stall(stall), .br_taken(br_taken), .br_target(br_target), .halt(halt)
    );
    always #5 clk = ~clk;
    // ctl={rst,gnt,rvalid}, sb={stall,br_taken}, ex={req,valid,halt}
    function automatic vec_t v(logic [2:0] c, logic [15:0] rd, logic [1:0] s, logic [15:0] t,
                               logic [2:0] e, logic [15:0] a, logic [15:0] i, logic [15:0] ip, logic [15:0] p);
        vec_t r;
        r.ctl = c; r.rdata = rd; r.sb = s; r.target = t;
        r.ex = e; r.addr = a; r.instr = i; r.ipc = ip; r.p1 = p;
        return r;
    endfunction
    task automatic apply(input string name, input int idx, input vec_t x);
        logic [66:0] got, exp;
        {rst, imem_gnt, imem_rvalid} = x.ctl;
        imem_rdata = x.rdata;
        {stall, br_taken} = x.sb;
        br_target = x.target;
        #1;
        got = {imem_req, instr_valid, halt, imem_addr, instr, instr_pc, pc_plus1};
        exp = {x.ex, x.addr, x.instr, x.ipc, x.p1};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: req/valid/halt=%b addr=%h instr=%h ipc=%h p1=%h, required %b %h %h %h %h",
                     name, idx, got[66:64], got[63:48], got[47:32], got[31:16], got[15:0],
                     x.ex, x.addr, x.instr, x.ipc, x.p1);
        end
        @(negedge clk);
    endtask
    initial begin
        {imem_gnt, imem_rvalid, stall, br_taken} = '0;
        imem_rdata = '0;
        br_target = '0;
        va.push_back(v(3'b100, 16'h0000, 2'b00, 16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        va.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        va.push_back(v(3'b001, 16'h1000, 2'b00, 16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        va.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b010, 16'h0000, 16'h1000, 16'h0000, 16'h0001));
        va.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0001, 16'h1000, 16'h0000, 16'h0001));
        va.push_back(v(3'b001, 16'h2000, 2'b00, 16'h0000, 3'b000, 16'h0001, 16'h1000, 16'h0000, 16'h0001));
        va.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b010, 16'h0001, 16'h2000, 16'h0001, 16'h0002));
        va.push_back(v(3'b001, 16'hDEAD, 2'b00, 16'h0000, 3'b100, 16'h0002, 16'h2000, 16'h0001, 16'h0002));
        va.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0002, 16'h2000, 16'h0001, 16'h0002));
        va.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b000, 16'h0002, 16'h2000, 16'h0001, 16'h0002));
        va.push_back(v(3'b001, 16'h3000, 2'b00, 16'h0000, 3'b000, 16'h0002, 16'h2000, 16'h0001, 16'h0002));
        va.push_back(v(3'b000, 16'h0000, 2'b01, 16'h0010, 3'b010, 16'h0002, 16'h3000, 16'h0002, 16'h0003));
        va.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0010, 16'h3000, 16'h0002, 16'h0003));
        va.push_back(v(3'b001, 16'hC005, 2'b00, 16'h0000, 3'b000, 16'h0010, 16'h3000, 16'h0002, 16'h0003));
        va.push_back(v(3'b000, 16'h0000, 2'b01, 16'h0016, 3'b010, 16'h0010, 16'hC005, 16'h0010, 16'h0011));
        va.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0016, 16'hC005, 16'h0010, 16'h0011));
        va.push_back(v(3'b001, 16'h4000, 2'b00, 16'h0000, 3'b000, 16'h0016, 16'hC005, 16'h0010, 16'h0011));
        va.push_back(v(3'b000, 16'h0000, 2'b11, 16'h00AA, 3'b010, 16'h0016, 16'h4000, 16'h0016, 16'h0017));
        va.push_back(v(3'b001, 16'hDEAD, 2'b10, 16'h0000, 3'b010, 16'h0016, 16'h4000, 16'h0016, 16'h0017));
        va.push_back(v(3'b000, 16'h0000, 2'b11, 16'h00BB, 3'b010, 16'h0016, 16'h4000, 16'h0016, 16'h0017));
        va.push_back(v(3'b000, 16'h0000, 2'b10, 16'h0000, 3'b010, 16'h0016, 16'h4000, 16'h0016, 16'h0017));
        va.push_back(v(3'b000, 16'h0000, 2'b00, 16'h00CC, 3'b010, 16'h0016, 16'h4000, 16'h0016, 16'h0017));
        va.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0017, 16'h4000, 16'h0016, 16'h0017));
        va.push_back(v(3'b001, 16'h5000, 2'b00, 16'h0000, 3'b000, 16'h0017, 16'h4000, 16'h0016, 16'h0017));
        va.push_back(v(3'b000, 16'h0000, 2'b01, 16'hFFFF, 3'b010, 16'h0017, 16'h5000, 16'h0017, 16'h0018));
        va.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'hFFFF, 16'h5000, 16'h0017, 16'h0018));
        va.push_back(v(3'b001, 16'h6000, 2'b00, 16'h0000, 3'b000, 16'hFFFF, 16'h5000, 16'h0017, 16'h0018));
        va.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b010, 16'hFFFF, 16'h6000, 16'hFFFF, 16'h0000));
        va.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0000, 16'h6000, 16'hFFFF, 16'h0000));
        va.push_back(v(3'b001, 16'hF000, 2'b00, 16'h0000, 3'b000, 16'h0000, 16'h6000, 16'hFFFF, 16'h0000));
        va.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b010, 16'h0000, 16'hF000, 16'h0000, 16'h0001));
`ifdef FETCH_HALT_EN
        va.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b001, 16'h0000, 16'hF000, 16'h0000, 16'h0001));
`else
        va.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0001, 16'hF000, 16'h0000, 16'h0001));
`endif
        // reset in WAIT with a late rvalid carrying 16'hBEEF
        vb.push_back(v(3'b100, 16'h0000, 2'b00, 16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b001, 16'h7000, 2'b00, 16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b000, 16'h0000, 2'b01, 16'h0040, 3'b010, 16'h0000, 16'h7000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b010, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0040, 16'h7000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b000, 16'h0040, 16'h7000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b100, 16'h0000, 2'b00, 16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b001, 16'hBEEF, 2'b00, 16'h0000, 3'b100, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b011, 16'hBEEF, 2'b00, 16'h0000, 3'b100, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b001, 16'h8000, 2'b00, 16'h0000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b010, 16'h0000, 16'h8000, 16'h0000, 16'h0001));
        vb.push_back(v(3'b000, 16'h0000, 2'b00, 16'h0000, 3'b100, 16'h0001, 16'h8000, 16'h0000, 16'h0001));
        @(negedge clk);
        foreach (va[i]) apply("vec_a", i, va[i]);
`ifdef FETCH_HALT_EN
        for (int k = 0; k < 20; k++) begin
            {imem_gnt, imem_rvalid, stall} = {1'b1, 1'b1, k[0]};
            imem_rdata = 16'h1234;
            #1;
            checks++;
            if (imem_req !== 1'b0 || halt !== 1'b1 || instr_valid !== 1'b0 || instr !== 16'hF000) begin
                fails++;
                $display("FAIL halt_hold[%0d]: req=%b halt=%b valid=%b instr=%h, required 0 1 0 f000",
                         k, imem_req, halt, instr_valid, instr);
            end
            @(negedge clk);
        end
`endif
        foreach (vb[i]) apply("vec_b", i, vb[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage program counter and instruction holding register for the 16-bit single-cycle datapath. Holds the architectural PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and presents the fetched instruction to decode/EX. On consumption it takes the EX-stage branch target when the branch is taken, otherwise PC+1. It detects HLT and freezes the machine.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- HLT_OP, 4'b1111, opcode (instr[15:12]) that halts fetch
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  16  fetch address (= pc)
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  read data valid this cycle
- imem_rdata  in  16  instruction word
- instr  out  16  held instruction to decode/EX
- instr_valid  out  1  instr is valid and awaiting consumption
- instr_pc  out  16  address of held instruction
- pc_plus1  out  16  instr_pc + 1 (sequential successor, fed to EX branch adder)
- stall  in  1  downstream not ready; instruction not consumed
- br_taken  in  1  EX resolved the held instruction as a taken branch
- br_target  in  16  EX-computed branch target
- halt  out  1  machine halted

## Operation
- Registers: pc[15:0], instr[15:0], instr_pc[15:0], state.
- States: FETCH, WAIT, HOLD, HALTED. Reset state FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_gnt -> WAIT. imem_addr is stable while imem_req is high.
- WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_pc<=pc, -> HOLD. imem_rvalid in FETCH or HOLD is ignored. imem_rvalid is never in the same cycle as its gnt.
- HOLD: instr_valid=1. The instruction is consumed in a cycle with stall=0:
  - If instr[15:12]==HLT_OP: -> HALTED, pc unchanged.
  - Else: pc <= br_taken ? br_target : pc+1, -> FETCH.
- br_taken/br_target are sampled only in the consumption cycle. They are ignored in every other cycle, including HOLD with stall=1.
- HALTED: halt=1, imem_req=0, instr_valid=0. The unit stays halted until rst.
- Arithmetic: pc+1 is 16-bit modulo, so 16'hFFFF -> 16'h0000. br_target is used verbatim.
- pc_plus1 = instr_pc+1, combinational, same wrap rule.

## Timing
- Reset values (async, immediate): pc=RESET_PC, state=FETCH, instr=16'h0000, instr_pc=16'h0000, instr_valid=0, halt=0. imem_req goes to 1 in the first cycle after rst deasserts.
- Zero-wait memory (gnt in cycle 0, rvalid in cycle 1): instr_valid is high from cycle 2. With stall=0, the next imem_req is in cycle 3. Minimum 3 cycles per instruction.
- Each added cycle of gnt or rvalid delay, or of stall, adds exactly one cycle.
- rst asserted in any state, including WAIT with a read outstanding: return to reset values. The late rvalid arrives in FETCH and is discarded.
- One outstanding request maximum. No new request until the held instruction is consumed.

## Configuration
- FETCH_HALT_EN defined: HLT detection and the HALTED state are present, as described above.
- FETCH_HALT_EN undefined: HLT_OP is treated as an ordinary instruction (pc <= pc+1 or branch target). halt is tied 0. HALTED state is absent.

## Test plan
- Reset, zero-wait memory returning 16'h1000, 16'h2000 at 0x0000/0x0001 with stall=0 -> imem_addr 0x0000, 0x0001, 0x0002. instr_valid pulses with instr 16'h1000 then 16'h2000, each 3 cycles apart.
- Held instr 16'hC005 at instr_pc 0x0010 with br_taken=1, br_target=0x0016 -> pc_plus1=0x0011, next imem_addr=0x0016.
- stall=1 for 4 cycles with br_taken toggling -> instr/instr_pc stable, no imem_req. After stall drops with br_taken=0, next imem_addr=instr_pc+1.
- pc=0xFFFF, non-branch instruction consumed -> next imem_addr=0x0000, pc_plus1 was 0x0000.
- HLT (16'hF000) consumed: with FETCH_HALT_EN -> halt=1 next cycle, no further imem_req for 20 cycles. Without FETCH_HALT_EN -> halt=0, next imem_addr=pc+1.
- rst pulsed while in WAIT, then imem_rvalid=1 with data 16'hBEEF -> outputs at reset values, 16'hBEEF never appears on instr, fetch restarts at RESET_PC.
